matrix_win_ctrl: RTL and testbench

MATRIX_WIN_CTRL -- requirements
Module: matrix_win_ctrl

---
 rtl/matrix_win_ctrl.sv | 122 ++++++++++++
 tb/tb_matrix_win_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/matrix_win_ctrl.sv
// rtl/matrix_win_ctrl.sv - frame sequencer gating pixel strobes into a 3x3 window generator
// Tracks the newest pixel's line/column and flags window position one cycle later.
module matrix_win_ctrl #(
  parameter logic [11:0] H_DISP = 12'd640,
  parameter logic [11:0] V_DISP = 12'd480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        din_vld,
  output logic        win_vld,
  output logic        mat_vld,
  output logic        mat_sof,
  output logic        mat_eof,
  output logic        mat_sol,
  output logic        mat_eol,
  output logic        mat_top,
  output logic [11:0] mat_row,
  output logic [11:0] mat_col,
  output logic        busy,
  output logic        frame_done,
  output logic        drop_err
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] col_q, col_d, row_q, row_d;
  logic        drop_err_q, drop_err_d;
  logic        mat_vld_q, mat_sof_q, mat_eof_q, mat_sol_q, mat_eol_q, mat_top_q;
  logic [11:0] mat_row_q, mat_col_q;
  logic        last_col, last_row;

  assign win_vld    = din_vld && (state_q == FILL || state_q == RUN);
  assign last_col   = (col_q == H_DISP - 12'd1);
  assign last_row   = (row_q == V_DISP - 12'd1);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    drop_err_d = drop_err_q;

    if (win_vld) begin
      col_d = last_col ? 12'd0 : col_q + 12'd1;
      if (last_col) row_d = last_row ? 12'd0 : row_q + 12'd1;
    end

    case (state_q)
      IDLE: begin
        // A strobe in the arming cycle is itself a drop, so it wins over the clear.
        if (din_vld)    drop_err_d = 1'b1;
        else if (start) drop_err_d = 1'b0;
        if (start) begin
          state_d = FILL;
          col_d   = 12'd0;
          row_d   = 12'd0;
        end
      end
      FILL: begin
        if (win_vld && last_col && last_row)          state_d = DONE;
        else if (win_vld && last_col && row_q == 12'd1) state_d = RUN;
      end
      RUN: begin
        if (win_vld && last_col && last_row) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= 12'd0;
      row_q      <= 12'd0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Flags are aligned to the generator's one-cycle window latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_vld_q <= 1'b0;
      mat_sof_q <= 1'b0;
      mat_eof_q <= 1'b0;
      mat_sol_q <= 1'b0;
      mat_eol_q <= 1'b0;
      mat_top_q <= 1'b0;
      mat_row_q <= 12'd0;
      mat_col_q <= 12'd0;
    end else begin
      mat_vld_q <= win_vld;
      mat_sof_q <= win_vld && row_q == 12'd0 && col_q == 12'd0;
      mat_eof_q <= win_vld && last_row && last_col;
      mat_sol_q <= win_vld && col_q == 12'd0;
      mat_eol_q <= win_vld && last_col;
      mat_top_q <= win_vld && row_q < 12'd2;
      if (win_vld) begin
        mat_row_q <= row_q;
        mat_col_q <= col_q;
      end
    end
  end

  assign mat_vld  = mat_vld_q;
  assign mat_sof  = mat_sof_q;
  assign mat_eof  = mat_eof_q;
  assign mat_sol  = mat_sol_q;
  assign mat_eol  = mat_eol_q;
  assign mat_top  = mat_top_q;
  assign mat_row  = mat_row_q;
  assign mat_col  = mat_col_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_matrix_win_ctrl.sv
// tb/tb_matrix_win_ctrl.sv - directed bench for matrix_win_ctrl on a 4x3 frame
module tb_matrix_win_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, din_vld;
  logic        win_vld, mat_vld, mat_sof, mat_eof, mat_sol, mat_eol, mat_top;
  logic [11:0] mat_row, mat_col;
  logic        busy, frame_done, drop_err;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  matrix_win_ctrl #(.H_DISP(12'd4), .V_DISP(12'd3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_vld(din_vld),
    .win_vld(win_vld), .mat_vld(mat_vld), .mat_sof(mat_sof), .mat_eof(mat_eof),
    .mat_sol(mat_sol), .mat_eol(mat_eol), .mat_top(mat_top),
    .mat_row(mat_row), .mat_col(mat_col),
    .busy(busy), .frame_done(frame_done), .drop_err(drop_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " win_vld"}, win_vld, 0);
    check({tag, " mat_vld"}, mat_vld, 0);
    check({tag, " flags"}, {mat_sof, mat_eof, mat_sol, mat_eol, mat_top}, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " frame_done"}, frame_done, 0);
  endtask

  // Expected window of pixel p for the 4x3 frame, worked out by hand:
  // rows 0..2 of 4 columns, top rows are lines 0 and 1.
  task automatic check_window(input int p);
    int r, c;
    r = p / 4;
    c = p % 4;
    check($sformatf("p%0d mat_vld", p), mat_vld, 1);
    check($sformatf("p%0d row", p), mat_row, r);
    check($sformatf("p%0d col", p), mat_col, c);
    check($sformatf("p%0d sof", p), mat_sof, p == 0);
    check($sformatf("p%0d eof", p), mat_eof, p == 11);
    check($sformatf("p%0d sol", p), mat_sol, c == 0);
    check($sformatf("p%0d eol", p), mat_eol, c == 3);
    check($sformatf("p%0d top", p), mat_top, r < 2);
  endtask

  task automatic arm();
    start   = 1'b1;
    din_vld = 1'b0;
    tick();
    start = 1'b0;
    check("arm busy", busy, 1);
    check("arm drop_err", drop_err, 0);
  endtask

  // Runs pixels first..last; gap inserts an idle cycle after each pixel,
  // mid_start >= 0 pulses start during the gap after that pixel.
  task automatic send_pixels(input int first, input int last, input bit gap, input int mid_start);
    for (int p = first; p <= last; p++) begin
      din_vld = 1'b1;
      #1;
      check($sformatf("p%0d win_vld", p), win_vld, 1);
      tick();
      din_vld = 1'b0;
      check_window(p);
      if (p != 11 && (gap || p == mid_start)) begin
        start = (p == mid_start);
        tick();
        start = 1'b0;
        check($sformatf("gap%0d mat_vld", p), mat_vld, 0);
        check($sformatf("gap%0d flags", p), {mat_sof, mat_eof, mat_sol, mat_eol, mat_top}, 0);
        check($sformatf("gap%0d hold", p), {mat_row, mat_col}, {12'(p / 4), 12'(p % 4)});
        check($sformatf("gap%0d busy", p), busy, 1);
        check($sformatf("gap%0d frame_done", p), frame_done, 0);
      end
    end
  endtask

  task automatic finish_frame(input string tag);
    check({tag, " frame_done"}, frame_done, 1);
    check({tag, " done busy"}, busy, 1);
    tick();
    check({tag, " frame_done drop"}, frame_done, 0);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle mat_vld"}, mat_vld, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    din_vld = 1'b1;
    #1;
    check_idle_outputs("reset");
    check("reset drop_err", drop_err, 0);
    check("reset pos", {mat_row, mat_col}, 0);
    tick();
    tick();
    rst_n   = 1'b1;
    din_vld = 1'b0;
    tick();

    // Stray strobes before arming.
    for (int i = 0; i < 3; i++) begin
      din_vld = 1'b1;
      #1;
      check("stray win_vld", win_vld, 0);
      tick();
      din_vld = 1'b0;
      check("stray mat_vld", mat_vld, 0);
    end
    check("stray drop_err", drop_err, 1);
    arm();

    // Frame 1: consecutive pixels.
    send_pixels(0, 11, 1'b0, -1);
    finish_frame("f1");

    // Frame 2: alternate-cycle pixels with a start pulse after pixel 5.
    arm();
    send_pixels(0, 11, 1'b1, 4);
    finish_frame("f2");

    // Frame 3: reset after pixel 6, then a fresh frame.
    arm();
    send_pixels(0, 5, 1'b0, -1);
    din_vld = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst pos", {mat_row, mat_col}, 0);
    tick();
    rst_n   = 1'b1;
    din_vld = 1'b0;
    tick();
    arm();
    send_pixels(0, 11, 1'b0, -1);
    finish_frame("f3");

    // Back-to-back: arm in the cycle right after DONE.
    arm();
    send_pixels(0, 11, 1'b0, -1);
    finish_frame("f4");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
